dac_sample_pacer: RTL and testbench

//  Paces signed synthesis samples into the AD5660 SPI driver at a fixed DAC update rate.
//  - Buffers incoming samples in a small FIFO.
//  - Saturates each sample to DAC width and converts it to offset binary.
//  - Builds the 24-bit AD5660 frame and issues a one-cycle go per sample tick.
//  - Tracks SPI driver completion through its SS_n output.
//  - Sits between the theremin tone generator (upstream) and the SPI driver (downstream).

---
 rtl/dac_sample_pacer.sv | 84 ++++++++
 tb/tb_dac_sample_pacer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: paces saturated offset-binary samples into the AD5660 SPI driver at a fixed rate
module dac_sample_pacer #(
  parameter int         IN_BITS    = 18,
  parameter int         DAC_BITS   = 16,
  parameter int         FRAME_BITS = 24,
  parameter logic [1:0] PD_MODE    = 2'b00,
  parameter int         fCLK       = 50_000_000,
  parameter int         fSAMPLE    = 48_000,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [IN_BITS-1:0]     in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          spi_ss_n,
  output logic [FRAME_BITS-1:0]         frame,
  output logic                          go,
  output logic                          underrun,
  output logic                          missed_tick
);
  localparam int TICK_MAX = fCLK / fSAMPLE - 1;
  localparam int CW = TICK_MAX > 0 ? $clog2(TICK_MAX + 1) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [IN_BITS-1:0] S_MAX = {{(IN_BITS-DAC_BITS+1){1'b0}}, {(DAC_BITS-1){1'b1}}};
  localparam logic signed [IN_BITS-1:0] S_MIN = ~S_MAX;
  localparam logic [DAC_BITS-1:0] MID = {1'b1, {(DAC_BITS-1){1'b0}}};
  localparam logic [FRAME_BITS-DAC_BITS-1:0] HDR = {{(FRAME_BITS-DAC_BITS-2){1'b0}}, PD_MODE};
  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] wd;
  logic [DAC_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DAC_BITS-1:0] sat, code;
  logic tick, push, pop, empty, full;
  assign tick = cnt == CW'(TICK_MAX);
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty = fifo_level == '0;
  assign full = fifo_level == (AW+1)'(FIFO_DEPTH);
  assign in_ready = !full && !reset;
  assign push = in_valid && in_ready;
  assign pop = tick && state == IDLE && !empty;
  assign sat = in_data > S_MAX ? ~MID : in_data < S_MIN ? MID : in_data[DAC_BITS-1:0];
  assign code = {~sat[DAC_BITS-1], sat[DAC_BITS-2:0]};
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // a driver that never pulls SS_n low releases the FSM after 16 cycles in WAIT_LOW
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = tick ? WAIT_LOW : IDLE;
      WAIT_LOW:  state_nx = !spi_ss_n ? WAIT_HIGH : wd == 4'd15 ? IDLE : WAIT_LOW;
      WAIT_HIGH: state_nx = spi_ss_n ? IDLE : WAIT_HIGH;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= code;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      wd          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame       <= {HDR, MID};
      go          <= 1'b0;
      underrun    <= 1'b0;
      missed_tick <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      wd          <= state == WAIT_LOW ? wd + 1'b1 : '0;
      go          <= tick && state == IDLE;
      underrun    <= tick && state == IDLE && empty;
      missed_tick <= tick && state != IDLE;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        frame  <= {HDR, mem[rd_ptr[AW-1:0]]};
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer: directed stimulus with a go-triggered scoreboard and a simple SS_n driver model
module tb_dac_sample_pacer;
  logic clk = 0, reset = 1, in_valid = 0, spi_ss_n = 1, model_en = 1;
  logic signed [17:0] in_data = '0;
  logic in_ready, go, underrun, missed_tick;
  logic [2:0] fifo_level;
  logic [23:0] frame;
  int tests = 0, fails = 0, missed = 0, low_len = 4;
  logic [24:0] exp_q [$];
  logic [24:0] mon_e;

  always #5 clk = ~clk;

  dac_sample_pacer #(.fCLK(1000), .fSAMPLE(100)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fifo_level(fifo_level), .spi_ss_n(spi_ss_n), .frame(frame), .go(go),
    .underrun(underrun), .missed_tick(missed_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_go(input logic [23:0] f, input logic u);
    exp_q.push_back({u, f});
  endtask

  task automatic wait_go(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!go && n < 60);
    chk("go_seen", go, 1);
  endtask

  task automatic push(input logic [17:0] d);
    in_data = d;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  // scoreboard: every go must match the oldest expected frame/underrun pair
  initial forever begin
    @(negedge clk);
    if (missed_tick) missed++;
    if (go) begin
      chk("go_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("frame", frame, mon_e[23:0]);
        chk("underrun_at_go", underrun, mon_e[24]);
      end
    end else if (underrun) chk("stray_underrun", underrun, 0);
  end

  initial forever begin
    @(negedge clk);
    if (go && model_en) begin
      repeat (2) @(negedge clk);
      spi_ss_n = 0;
      repeat (low_len) @(negedge clk);
      spi_ss_n = 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, m0, k;
    logic acc;
    expect_go(24'h008000, 1);
    repeat (3) @(negedge clk);
    chk("ready_in_reset", in_ready, 0);
    reset = 0;
    @(negedge clk);
    chk("rst_frame", frame, 24'h008000);
    chk("rst_go", go, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
    wait_go(n);
    chk("first_go_latency", n, 9);
    expect_go(24'h008400, 0);
    push(18'sh00400);
    chk("level_one", fifo_level, 1);
    wait_go(n);
    chk("level_after_pop", fifo_level, 0);
    expect_go(24'h00FFFF, 0);
    expect_go(24'h000000, 0);
    expect_go(24'h007FFF, 0);
    push(18'sh1FFFF);
    push(18'sh20000);
    push(18'sh3FFFF);
    chk("level_three", fifo_level, 3);
    repeat (3) wait_go(n);
    expect_go(24'h007FFF, 1);
    wait_go(n);
    @(negedge clk);
    chk("underrun_one_cycle", underrun, 0);
    for (int i = 1; i <= 5; i++) expect_go(24'h008000 + 24'(i), 0);
    k = 1;
    in_data = 18'sd1;
    in_valid = 1;
    acc = in_ready;
    n = 0;
    while (k <= 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (acc) begin
        k++;
        in_data = 18'(k);
      end
      if (k == 5 && acc) begin
        chk("full_not_ready", in_ready, 0);
        chk("full_level", fifo_level, 4);
      end
      if (k == 5 && go) begin
        chk("ready_after_pop", in_ready, 1);
        chk("level_after_full_pop", fifo_level, 3);
      end
      acc = in_ready;
    end
    in_valid = 0;
    chk("sample5_accepted", k, 6);
    repeat (4) wait_go(n);
    low_len = 15;
    m0 = missed;
    repeat (12) @(negedge clk);
    chk("missed_tick_once", missed - m0, 1);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_go", go, 0);
    chk("rst_mid_frame", frame, 24'h008000);
    chk("rst_mid_level", fifo_level, 0);
    reset = 0;
    low_len = 4;
    model_en = 0;
    expect_go(24'h008000, 1);
    expect_go(24'h008000, 1);
    wait_go(n);
    chk("go_after_reset_latency", n, 10);
    m0 = missed;
    wait_go(n);
    chk("timeout_go_gap", n, 20);
    chk("timeout_missed", missed - m0, 1);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
